// File: rtl/nn_frame_controller.sv
// Pixel-stream front end and argmax back end for the neural network block.
// Converts and writes one frame to RAM, pulses Compute, then scans the class outputs.
module nn_frame_controller #(
  parameter int NUM_PIXELS  = 784,
  parameter int NUM_CLASSES = 10,
  parameter int ADDR_BASE   = 0,
  parameter int ADDR_W      = 10
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      PixelValid,
  input  logic [7:0]                PixelData,
  output logic                      PixelReady,
  output logic                      WrEn,
  output logic [ADDR_W-1:0]         WrAddr,
  output logic [15:0]               WrData,
  output logic                      Compute,
  input  logic                      NNReady,
  input  logic [16*NUM_CLASSES-1:0] Probability,
  output logic [3:0]                Digit,
  output logic                      DigitValid,
  output logic                      Busy
);

  localparam int CNT_W = $clog2(NUM_PIXELS + 1);

  typedef enum logic [2:0] {
    S_LOAD, S_START, S_WAIT, S_SETTLE, S_SCAN, S_DONE
  } state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_count;
  logic [3:0]         r_scan;
  logic signed [15:0] r_best;
  logic [3:0]         r_best_idx;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [15:0]        r_wr_data;
  logic [3:0]         r_digit;

  logic               w_accept;
  logic               w_last_pix;
  logic               w_last_class;
  logic signed [15:0] w_prob;
  logic               w_take;

  assign PixelReady = (r_state == S_LOAD);
  assign Compute    = (r_state == S_START);
  assign DigitValid = (r_state == S_DONE);
  assign Busy       = (r_state != S_LOAD);
  assign WrEn       = r_wr_en;
  assign WrAddr     = r_wr_addr;
  assign WrData     = r_wr_data;
  assign Digit      = r_digit;

  assign w_accept     = PixelValid & PixelReady;
  assign w_last_pix   = w_accept && (r_count == CNT_W'(NUM_PIXELS - 1));
  assign w_last_class = (r_scan == 4'(NUM_CLASSES - 1));

  always_comb begin
    w_prob = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (r_scan == 4'(i)) w_prob = Probability[16*i +: 16];
    end
  end

  // Strict greater-than keeps the lower index on ties.
  assign w_take = (r_scan == 4'd0) || (w_prob > r_best);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:   if (w_last_pix) w_next = S_START;
      S_START:  w_next = S_WAIT;
      S_WAIT:   if (NNReady) w_next = S_SETTLE;
      S_SETTLE: w_next = S_SCAN;
      S_SCAN:   if (w_last_class) w_next = S_DONE;
      S_DONE:   w_next = S_LOAD;
      default:  w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= S_LOAD;
      r_count    <= '0;
      r_scan     <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_digit    <= '0;
    end else begin
      r_state <= w_next;
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_addr <= ADDR_W'(ADDR_BASE + int'(r_count));
        r_wr_data <= {5'b0, PixelData, PixelData[7:5]};
        r_count   <= w_last_pix ? '0 : r_count + 1'b1;
      end
      if (r_state == S_SCAN) begin
        if (w_take) begin
          r_best     <= w_prob;
          r_best_idx <= r_scan;
        end
        r_scan <= w_last_class ? 4'd0 : r_scan + 4'd1;
        if (w_last_class) r_digit <= w_take ? r_scan : r_best_idx;
      end
    end
  end

endmodule

// File: tb/tb_nn_frame_controller.sv
// Scoreboard bench for nn_frame_controller: the stimulus side queues expected
// writes, Compute pulses and digits; a negedge monitor pops and compares them.
module tb_nn_frame_controller;
  localparam int NP = 784;
  localparam int NC = 10;
  localparam int ADDR_BASE = 0;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic           PixelValid = 1'b0;
  logic [7:0]     PixelData = '0;
  logic           PixelReady;
  logic           WrEn;
  logic [9:0]     WrAddr;
  logic [15:0]    WrData;
  logic           Compute;
  logic           NNReady = 1'b0;
  logic [16*NC-1:0] Probability = '0;
  logic [3:0]     Digit;
  logic           DigitValid;
  logic           Busy;

  nn_frame_controller #(
    .NUM_PIXELS(NP), .NUM_CLASSES(NC), .ADDR_BASE(ADDR_BASE), .ADDR_W(10)
  ) dut (
    .Clk(Clk), .Reset(Reset), .PixelValid(PixelValid), .PixelData(PixelData),
    .PixelReady(PixelReady), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .Compute(Compute), .NNReady(NNReady), .Probability(Probability),
    .Digit(Digit), .DigitValid(DigitValid), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int dig; int cyc; } dg_t;
  wr_t exp_wr[$];
  int  exp_comp[$];
  dg_t exp_dg[$];

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic void flag(string name);
    checks++;
    failures++;
    $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
  endfunction

  // Monitor
  always @(negedge Clk) begin
    if (WrEn === 1'b1) begin
      if (exp_wr.size() == 0) flag("spurious_write");
      else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_addr", WrAddr, e.addr);
        chk("wr_data", WrData, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (Compute === 1'b1) begin
      if (exp_comp.size() == 0) flag("spurious_compute");
      else begin
        chk("compute_cycle", cyc, exp_comp.pop_front());
        chk("ready_in_start", PixelReady, 0);
        chk("busy_in_start", Busy, 1);
      end
    end
    if (DigitValid === 1'b1) begin
      if (exp_dg.size() == 0) flag("spurious_digit");
      else begin
        dg_t d;
        d = exp_dg.pop_front();
        chk("digit", Digit, d.dig);
        chk("digit_cycle", cyc, d.cyc);
        chk("busy_in_done", Busy, 1);
      end
    end
  end

  task automatic check_reset_state();
    chk("rst_wren", WrEn, 0);
    chk("rst_wraddr", WrAddr, 0);
    chk("rst_wrdata", WrData, 0);
    chk("rst_compute", Compute, 0);
    chk("rst_digit", Digit, 0);
    chk("rst_digitvalid", DigitValid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_ready", PixelReady, 1);
    repeat (5) begin
      @(posedge Clk); #1;
      chk("idle_ready", PixelReady, 1);
      chk("idle_busy", Busy, 0);
      chk("idle_wren", WrEn, 0);
      chk("idle_compute", Compute, 0);
      chk("idle_digitvalid", DigitValid, 0);
    end
  endtask

  // Streams n_pix pixels; for a full frame also answers with NNReady after
  // wait_cyc WAIT cycles and returns the cycle a following frame may accept in.
  task automatic run_frame(input int n_pix, input int duty, input int wait_cyc,
                           input logic [16*NC-1:0] prob, input int exp_dig,
                           input int exp_first, input bit hold, output int next_first);
    int acc = 0;
    int guard = 0;
    int last = 0;
    int p;
    wr_t w;
    dg_t d;
    next_first = -1;
    while (acc < n_pix && guard < 4000) begin
      @(posedge Clk); #1;
      PixelValid = ($urandom_range(99) < duty);
      PixelData = 8'(acc % 256);
      #1;
      chk("ready_in_load", PixelReady, 1);
      chk("busy_in_load", Busy, 0);
      if (PixelValid && PixelReady) begin
        if (acc == 0 && exp_first >= 0) chk("first_accept_cycle", cyc, exp_first);
        p = acc % 256;
        w.addr = ADDR_BASE + acc;
        w.data = p * 8 + p / 32;
        w.cyc  = cyc + 1;
        exp_wr.push_back(w);
        last = cyc;
        acc++;
      end
      guard++;
    end
    if (acc < n_pix) chk("frame_accept_timeout", acc, n_pix);
    if (n_pix == NP) begin
      exp_comp.push_back(last + 1);
      @(posedge Clk); #1;
      PixelValid = hold;
      PixelData = 8'hA5;
      repeat (wait_cyc + 1) @(posedge Clk);
      #1;
      Probability = prob;
      NNReady = 1'b1;
      d.dig = exp_dig;
      d.cyc = cyc + 12;
      exp_dg.push_back(d);
      @(posedge Clk); #1;
      NNReady = 1'b0;
      repeat (11) @(posedge Clk);
      #1;
      next_first = cyc + 1;
    end
  endtask

  function automatic logic [16*NC-1:0] fill(input logic [15:0] v);
    logic [16*NC-1:0] r;
    for (int i = 0; i < NC; i++) r[16*i +: 16] = v;
    return r;
  endfunction

  initial begin
    logic [16*NC-1:0] pa, pb, pc, pd, pe;
    int nf, nf2;
    pa = fill(16'h0100); pa[16*7 +: 16] = 16'h0700;
    pb = fill(16'hF000); pb[16*3 +: 16] = 16'hFF00; pb[16*8 +: 16] = 16'hFF00;
    pc = fill(16'h0000); pc[16*0 +: 16] = 16'h8000; pc[16*9 +: 16] = 16'h7FFF;
    pd = fill(16'h0100);
    pe = fill(16'h1233); pe[16*4 +: 16] = 16'h1234;

    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    check_reset_state();

    run_frame(NP, 50, 50, pa, 7, -1, 1'b0, nf);
    run_frame(NP, 50, 0, pb, 3, -1, 1'b0, nf);

    // Abort a frame part-way with Reset
    run_frame(400, 50, 0, '0, 0, -1, 1'b0, nf);
    @(posedge Clk); #1;
    PixelValid = 1'b0;
    Reset = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check_reset_state();

    run_frame(NP, 50, 5, pc, 9, -1, 1'b0, nf);

    // Back-to-back frames with PixelValid held high
    run_frame(NP, 100, 3, pd, 0, -1, 1'b1, nf);
    run_frame(NP, 100, 2, pe, 4, nf, 1'b0, nf2);

    repeat (5) @(posedge Clk);
    #1;
    chk("pending_writes", exp_wr.size(), 0);
    chk("pending_computes", exp_comp.size(), 0);
    chk("pending_digits", exp_dg.size(), 0);
    chk("final_digit_hold", Digit, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
